// File: rtl/ika87ad_mc_pkg.sv
// ika87ad_mc_pkg: microword layout, CYC codes and FSM states shared by the microcode sequencer
package ika87ad_mc_pkg;
  localparam int UW = 18;
  localparam int CYC_LSB = 0;
  localparam int CYC_MSB = 1;
  localparam int END_BIT = 2;
  localparam logic [1:0] RD1 = 2'd0;
  localparam logic [1:0] RD2 = 2'd1;
  localparam logic [1:0] RD3 = 2'd2;
  localparam logic [1:0] RD4 = 2'd3;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_e;
endpackage

// File: rtl/ika87ad_mc_sequencer.sv
// ika87ad_mc_sequencer: microcode sequencer; start/entry/hold/abort in, ROM tick/addr/data, uop/valid/busy/done out
module ika87ad_mc_sequencer
  import ika87ad_mc_pkg::*;
(
  input  logic          i_CLK,
  input  logic          i_RST,
  input  logic          i_CEN,
  input  logic          i_START,
  input  logic [7:0]    i_ENTRY_ADDR,
  input  logic          i_HOLD,
  input  logic          i_ABORT,
  output logic          o_MCROM_READ_TICK,
  output logic [7:0]    o_MCROM_ADDR,
  input  logic [UW-1:0] i_MCROM_DATA,
  output logic [UW-1:0] o_UOP,
  output logic          o_UOP_VALID,
  output logic          o_BUSY,
  output logic          o_DONE
);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [UW-1:0] uop_q, uop_d;
  logic tick, valid, done;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    uop_d = uop_q;
    tick = 1'b0;
    valid = 1'b0;
    done = 1'b0;
    if (i_CEN && i_ABORT) begin
      state_d = IDLE;
      cnt_d = 2'd0;
    end else if (i_CEN) begin
      case (state_q)
        IDLE: if (i_START) begin
          addr_d = i_ENTRY_ADDR;
          tick = 1'b1;
          state_d = FETCH;
        end
        FETCH: begin
          uop_d = i_MCROM_DATA;
          valid = 1'b1;
          cnt_d = i_MCROM_DATA[CYC_MSB:CYC_LSB];
          state_d = EXEC;
        end
        EXEC: if (cnt_q != 2'd0) cnt_d = i_HOLD ? cnt_q : cnt_q - 2'd1;
        else if (!i_HOLD) begin
          done = uop_q[END_BIT];
          tick = !uop_q[END_BIT] || i_START;
          addr_d = !uop_q[END_BIT] ? addr_q + 8'd1 : i_START ? i_ENTRY_ADDR : addr_q;
          state_d = tick ? FETCH : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      addr_q <= 8'h00;
      uop_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      uop_q <= uop_d;
    end
  end
  assign o_MCROM_READ_TICK = tick & ~i_RST;
  assign o_UOP_VALID = valid & ~i_RST;
  assign o_DONE = done & ~i_RST;
  assign o_MCROM_ADDR = addr_q;
  assign o_UOP = uop_q;
  assign o_BUSY = state_q != IDLE;
endmodule
